// File: rtl/br_redirect_ctrl_pkg.sv
// Shared definitions for the branch redirect controller: FSM state encoding,
// default widths and the target alignment mask used by BR_MISALIGN_CHK_EN builds.
package br_redirect_ctrl_pkg;

  localparam int ADDR_W_DEF  = 64;
  localparam int MAX_OUT_DEF = 4;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_FLUSH    = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;
  localparam logic [1:0] ST_EXC      = 2'd3;

  // Instruction fetch targets must be word aligned.
  localparam logic [1:0] MISALIGN_MASK = 2'b11;

  function automatic logic tgt_misaligned(input logic [1:0] lsb);
    return (lsb & MISALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/br_redirect_ctrl_if.sv
// Signal bundle between the EX branch unit, the IF fetch logic and the redirect
// controller; master is the controller side, slave is the pipeline side.
interface br_redirect_ctrl_if
  import br_redirect_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              ex_valid_i;
  logic              br_e_i;
  logic [ADDR_W-1:0] br_addr_i;
  logic              ex_stall_o;
  logic              flush_o;
  logic              redirect_valid_o;
  logic              redirect_ready_i;
  logic [ADDR_W-1:0] redirect_pc_o;
  logic              fetch_req_fire_i;
  logic              fetch_rsp_fire_i;
  logic              drop_rsp_o;
  logic              misalign_exc_o;
  logic [ADDR_W-1:0] misalign_tval_o;

  modport master (
    input  ex_valid_i, br_e_i, br_addr_i, redirect_ready_i,
           fetch_req_fire_i, fetch_rsp_fire_i,
    output ex_stall_o, flush_o, redirect_valid_o, redirect_pc_o,
           drop_rsp_o, misalign_exc_o, misalign_tval_o
  );

  modport slave (
    output ex_valid_i, br_e_i, br_addr_i, redirect_ready_i,
           fetch_req_fire_i, fetch_rsp_fire_i,
    input  ex_stall_o, flush_o, redirect_valid_o, redirect_pc_o,
           drop_rsp_o, misalign_exc_o, misalign_tval_o
  );

endinterface

// File: rtl/br_redirect_ctrl_fetch_inflight_cnt.sv
// In-flight fetch counter plus wrong-path drop counter; flags responses that
// belong to fetches issued before the most recent redirect.
module br_redirect_ctrl_fetch_inflight_cnt
  import br_redirect_ctrl_pkg::*;
#(
  parameter int MAX_OUT = MAX_OUT_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic req_fire_i,
  input  logic rsp_fire_i,
  input  logic load_drop_i,
  output logic drop_rsp_o
);

  localparam int              CNT_W   = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  assign drop_rsp_o = rsp_fire_i && (drop_cnt_q != '0);

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (req_fire_i && !rsp_fire_i && (out_cnt_q != CNT_MAX)) begin
      out_cnt_d = out_cnt_q + CNT_W'(1);
    end else if (!req_fire_i && rsp_fire_i && (out_cnt_q != '0)) begin
      out_cnt_d = out_cnt_q - CNT_W'(1);
    end
  end

  // On a redirect everything still in flight after this cycle is wrong-path;
  // a response landing in the accept cycle enters IF/ID and dies with the flush.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (load_drop_i) begin
      drop_cnt_d = out_cnt_d;
    end else if (drop_rsp_o) begin
      drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: rtl/br_redirect_ctrl.sv
// Front-end redirect sequencer: captures a taken branch target from EX, flushes
// IF/ID, hands the target to fetch and drops wrong-path responses.
// Optional target alignment exception is enabled with `define BR_MISALIGN_CHK_EN.
module br_redirect_ctrl
  import br_redirect_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int MAX_OUT = MAX_OUT_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  br_redirect_ctrl_if.master bus
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              accept;
  logic              in_exc;

  assign accept = (state_q == ST_IDLE) && bus.ex_valid_i && bus.br_e_i;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          tgt_d = bus.br_addr_i;
`ifdef BR_MISALIGN_CHK_EN
          state_d = tgt_misaligned(bus.br_addr_i[1:0]) ? ST_EXC : ST_FLUSH;
`else
          state_d = ST_FLUSH;
`endif
        end
      end
      ST_FLUSH:    state_d = ST_REDIRECT;
      ST_REDIRECT: if (bus.redirect_ready_i) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

`ifdef BR_MISALIGN_CHK_EN
  assign in_exc              = (state_q == ST_EXC);
  assign bus.misalign_exc_o  = in_exc;
  assign bus.misalign_tval_o = in_exc ? tgt_q : '0;
`else
  assign in_exc              = 1'b0;
  assign bus.misalign_exc_o  = 1'b0;
  assign bus.misalign_tval_o = '0;
`endif

  // All outputs decode from registered state so reset clears them at once.
  assign bus.ex_stall_o       = (state_q != ST_IDLE);
  assign bus.flush_o          = (state_q == ST_FLUSH) || in_exc;
  assign bus.redirect_valid_o = (state_q == ST_REDIRECT);
  assign bus.redirect_pc_o    = (state_q == ST_REDIRECT) ? tgt_q : '0;

  br_redirect_ctrl_fetch_inflight_cnt #(
    .MAX_OUT (MAX_OUT)
  ) u_inflight (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_fire_i  (bus.fetch_req_fire_i),
    .rsp_fire_i  (bus.fetch_rsp_fire_i),
    .load_drop_i (accept),
    .drop_rsp_o  (bus.drop_rsp_o)
  );

endmodule

// File: tb/tb_br_redirect_ctrl.sv
// Self-checking bench for br_redirect_ctrl: directed scenarios followed by random
// traffic, checked every cycle against a cycle-count and fetch-queue reference model.
module tb_br_redirect_ctrl;

  localparam int ADDR_W  = 64;
  localparam int MAX_OUT = 4;

`ifdef BR_MISALIGN_CHK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  br_redirect_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  br_redirect_ctrl #(
    .ADDR_W  (ADDR_W),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: age = cycles since the branch was accepted (-1 when idle);
  // stale_q holds one entry per in-flight fetch, 1 = issued on the wrong path.
  int          age = -1;
  bit          mis = 1'b0;
  logic [63:0] tgt = '0;
  bit          stale_q[$];
  int          drops_seen = 0;
  int          valid_seen = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got 0x%0h expected 0x%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic ev, input logic be, input logic [63:0] addr,
                       input logic rdy, input logic req, input logic rsp);
    bus.ex_valid_i       = ev;
    bus.br_e_i           = be;
    bus.br_addr_i        = addr;
    bus.redirect_ready_i = rdy;
    bus.fetch_req_fire_i = req;
    bus.fetch_rsp_fire_i = rsp;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_stall"}, bus.ex_stall_o, 0);
    check_val({tag, "_flush"}, bus.flush_o, 0);
    check_val({tag, "_valid"}, bus.redirect_valid_o, 0);
    check_val({tag, "_pc"},    bus.redirect_pc_o, 0);
    check_val({tag, "_drop"},  bus.drop_rsp_o, 0);
    check_val({tag, "_exc"},   bus.misalign_exc_o, 0);
    check_val({tag, "_tval"},  bus.misalign_tval_o, 0);
  endtask

  // One clock cycle: drive at negedge, check at negedge+1, then advance the model
  // to what the next rising edge should produce.
  task automatic step(input logic ev, input logic be, input logic [63:0] addr,
                      input logic rdy, input logic req, input logic rsp);
    bit          exp_stall, exp_flush, exp_valid, exp_exc, exp_drop, acc;
    logic [63:0] exp_pc, exp_tval;
    @(negedge clock);
    cyc++;
    drive(ev, be, addr, rdy, req, rsp);
    exp_stall = (age >= 1);
    exp_flush = (age == 1);
    exp_valid = (age >= 2);
    exp_pc    = exp_valid ? tgt : 64'd0;
    exp_exc   = (age == 1) && mis;
    exp_tval  = exp_exc ? tgt : 64'd0;
    exp_drop  = rsp && (stale_q.size() > 0) && stale_q[0];
    #1;
    check_val("stall", bus.ex_stall_o, exp_stall);
    check_val("flush", bus.flush_o, exp_flush);
    check_val("redir_valid", bus.redirect_valid_o, exp_valid);
    check_val("redir_pc", bus.redirect_pc_o, exp_pc);
    check_val("drop_rsp", bus.drop_rsp_o, exp_drop);
    check_val("mis_exc", bus.misalign_exc_o, exp_exc);
    check_val("mis_tval", bus.misalign_tval_o, exp_tval);
    if (bus.drop_rsp_o)       drops_seen++;
    if (bus.redirect_valid_o) valid_seen++;
    $display("cyc=%0d age=%0d ev=%0b br=%0b rdy=%0b req=%0b rsp=%0b | stall=%0b flush=%0b valid=%0b pc=%0h drop=%0b exc=%0b",
             cyc, age, ev, be, rdy, req, rsp, bus.ex_stall_o, bus.flush_o,
             bus.redirect_valid_o, bus.redirect_pc_o, bus.drop_rsp_o, bus.misalign_exc_o);

    acc = (age < 0) && ev && be;
    if (rsp && stale_q.size() > 0) stale_q.delete(0);
    if (acc) foreach (stale_q[i]) stale_q[i] = 1'b1;
    if (req) stale_q.push_back(acc);
    if (acc) begin
      age = 1;
      tgt = addr;
      mis = MIS_EN && (addr[1:0] != 2'b00);
    end else if (age == 1) begin
      age = mis ? -1 : 2;
    end else if (age >= 2) begin
      age = rdy ? -1 : age + 1;
    end
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check_all_zero("reset");
    @(negedge clock);
    reset_n = 1'b1;
    idle_step();

    // Idle taken jump with immediate ready
    valid_seen = 0; drops_seen = 0;
    step(1'b1, 1'b1, 64'h8000_0100, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    check_val("jump_valid_cycles", valid_seen, 1);
    check_val("jump_drops", drops_seen, 0);

    // Back-pressure: ready low for 5 redirect cycles
    valid_seen = 0;
    step(1'b1, 1'b1, 64'h0000_0040_0000_1230, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b1, 64'hdead_beef_0000_0000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    idle_step();
    check_val("bp_valid_cycles", valid_seen, 6);

    // Wrong-path drain: 3 outstanding + 1 request on the accept cycle
    drops_seen = 0;
    repeat (3) step(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 64'h8000_0200, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    check_val("drain_drops", drops_seen, 4);

    // Simultaneous req+rsp on the accept cycle with 2 outstanding
    drops_seen = 0;
    repeat (2) step(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 64'h8000_0300, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    check_val("simul_drops", drops_seen, 2);

    // Reset pulled in REDIRECT with wrong-path fetches pending
    repeat (2) step(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 64'h8000_0400, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    #1;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clock);
    reset_n = 1'b1;
    age = -1;
    mis = 1'b0;
    stale_q.delete();
    drops_seen = 0; valid_seen = 0;
    step(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 64'h1234_5678_9abc_def0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    idle_step();
    check_val("post_rst_drops", drops_seen, 0);
    check_val("post_rst_valid", valid_seen, 1);

    // Misaligned target: exception with the macro, normal redirect without
    valid_seen = 0;
    step(1'b1, 1'b1, 64'h8000_0102, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    check_val("misalign_valid_cycles", valid_seen, MIS_EN ? 0 : 1);

    // Random traffic, legal fetch handshakes only
    for (int i = 0; i < 400; i++) begin
      logic        r_ev, r_be, r_rdy, r_req, r_rsp;
      logic [63:0] r_addr;
      r_ev   = ($urandom_range(0, 3) == 0);
      r_be   = ($urandom_range(0, 1) == 1);
      r_addr = {$urandom, $urandom};
      r_rdy  = ($urandom_range(0, 2) == 0);
      r_req  = (age < 0) && (stale_q.size() < MAX_OUT) && ($urandom_range(0, 1) == 1);
      r_rsp  = (stale_q.size() > 0) && ($urandom_range(0, 2) != 0);
      step(r_ev, r_be, r_addr, r_rdy, r_req, r_rsp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
